key_store_cam: RTL and testbench
================================

Name: key_store_cam

Overview:
- Storage and match stage for the cache controller: holds NUM_ENTRIES key/value slots plus per-slot used bits.
- Performs registered associative key lookups and supplies hit, one-hot match index, used vector and occupancy to the upsert/get/delete FSMs.
- Consumes their one-hot write/delete commands.
- Sits directly upstream of the upsert FSM (feeds hit/idx/used) and downstream of it (consumes write/idx).

Parameters:
- NUM_ENTRIES, 16, number of slots (>=2)
- KEY_WIDTH, 64, key bits
- VALUE_WIDTH, 64, value bits
- CNT_WIDTH, $clog2(NUM_ENTRIES+1), occupancy counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lookup_valid  in  1  lookup request strobe, one request per cycle max
- lookup_key  in  KEY_WIDTH  key to match, sampled when lookup_valid=1
- resp_valid  out  1  lookup result valid, single-cycle pulse
- resp_hit  out  1  key found in a used slot
- resp_idx  out  NUM_ENTRIES  one-hot matching slot, 0 on miss
- resp_value  out  VALUE_WIDTH  value of matching slot, 0 on miss
- used  out  NUM_ENTRIES  current used bits (registered state)
- full  out  1  all slots used
- count  out  CNT_WIDTH  number of used slots
- wr_en  in  1  write strobe
- wr_idx  in  NUM_ENTRIES  one-hot target slot
- wr_key  in  KEY_WIDTH  key to store
- wr_value  in  VALUE_WIDTH  value to store
- del_en  in  1  delete strobe
- del_idx  in  NUM_ENTRIES  one-hot slot to free
- cmd_err  out  1  one-cycle pulse: malformed write/delete rejected
- multi_hit  out  1  sticky: a lookup matched more than one slot

Behaviour:
- Reset (async, rst_n=0): used=0, count=0, full=0, resp_valid=0, resp_hit=0, resp_idx=0, resp_value=0, cmd_err=0, multi_hit=0. Key/value arrays need no reset; all outputs are gated by used bits.
- Lookup latency is 1 cycle. lookup_valid=1 in cycle N gives resp_valid=1 in cycle N+1 with the result, and resp_valid=0 otherwise. Back-to-back requests produce back-to-back responses, with no stall and no ready.
- Match rule: slot i matches iff used[i] and key[i]==lookup_key, evaluated against the state at the start of cycle N. A write/delete in cycle N is not visible to a lookup in cycle N; it is visible to a lookup in cycle N+1.
- Multiple matches: report the lowest-index match only (resp_idx stays one-hot) and set multi_hit, which is cleared only by reset.
- resp_* hold their last values while resp_valid=0.
- Write, accepted when wr_en=1 and wr_idx has exactly one bit set: key, value stored and used bit set at the clock edge. Writing an already-used slot overwrites it (update), with no count change.
- Delete, accepted when del_en=1 and del_idx is exactly one-hot: used bit cleared. Deleting an unused slot is a no-op with no error.
- Malformed command (wr_idx or del_idx zero or multi-hot while its enable is set): command ignored, cmd_err=1 the next cycle.
- Simultaneous write and delete:
  - Same slot: the write wins; the slot ends used with the new data.
  - Different slots: both take effect.
- count is registered and equals popcount(used) every cycle. Updates per cycle are +1, -1, 0, or 0 when a write-new and a delete-used coincide. full = (count==NUM_ENTRIES), registered alongside.
- Reset mid-operation drops any pending response; resp_valid is 0 in the first cycle after deassertion.

Test Plan:
- Reset, then lookup key 0xA5 -> next cycle resp_valid=1, resp_hit=0, resp_idx=0, resp_value=0; used=0, count=0, full=0.
- Write slot 3 (wr_idx=0x0008) key 0x11 value 0xBEEF; lookup 0x11 one cycle later -> resp_hit=1, resp_idx=0x0008, resp_value=0xBEEF, count=1.
- Lookup 0x11 in the same cycle as that write -> resp_hit=0 (pre-write state); repeat lookup next cycle -> resp_hit=1.
- Fill all 16 slots with keys 0..15 -> count=16, full=1. Delete slot 15 and write slot 15 (key 0x99) in the same cycle -> used[15]=1, count=16, lookup 0x99 hits idx 0x8000.
- wr_en=1 with wr_idx=0x0003 -> no state change, cmd_err pulses once. Write key 0x22 into slots 1 and 5 separately, then lookup 0x22 -> resp_idx=0x0002 and multi_hit=1, still set after further lookups.
- Issue lookup_valid, then assert rst_n=0 before the response edge -> resp_valid=0 throughout reset and in the first cycle after release; used=0.

Source files
------------

// File: rtl/key_store_cam_if.sv
// key_store_cam_if: lookup, response, write/delete command and status bundle
// between the CAM (slave) and the upsert/get/delete FSMs (master).
interface key_store_cam_if #(
   parameter int NUM_ENTRIES = 16,
   parameter int KEY_WIDTH   = 64,
   parameter int VALUE_WIDTH = 64,
   parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
);
   logic                   lookup_valid;
   logic [KEY_WIDTH-1:0]   lookup_key;
   logic                   resp_valid;
   logic                   resp_hit;
   logic [NUM_ENTRIES-1:0] resp_idx;
   logic [VALUE_WIDTH-1:0] resp_value;
   logic [NUM_ENTRIES-1:0] used;
   logic                   full;
   logic [CNT_WIDTH-1:0]   count;
   logic                   wr_en;
   logic [NUM_ENTRIES-1:0] wr_idx;
   logic [KEY_WIDTH-1:0]   wr_key;
   logic [VALUE_WIDTH-1:0] wr_value;
   logic                   del_en;
   logic [NUM_ENTRIES-1:0] del_idx;
   logic                   cmd_err;
   logic                   multi_hit;
   modport master (
      output lookup_valid, lookup_key, wr_en, wr_idx, wr_key, wr_value, del_en, del_idx,
      input  resp_valid, resp_hit, resp_idx, resp_value, used, full, count, cmd_err, multi_hit
   );
   modport slave (
      input  lookup_valid, lookup_key, wr_en, wr_idx, wr_key, wr_value, del_en, del_idx,
      output resp_valid, resp_hit, resp_idx, resp_value, used, full, count, cmd_err, multi_hit
   );
endinterface

// File: rtl/key_store_cam.sv
// key_store_cam: key/value slot store with registered associative lookup,
// one-hot write/delete commands, occupancy tracking and malformed-command flagging.
module key_store_cam #(
   parameter int NUM_ENTRIES = 16,
   parameter int KEY_WIDTH   = 64,
   parameter int VALUE_WIDTH = 64,
   parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
) (
   input logic             clk,
   input logic             rst_n,
   key_store_cam_if.slave  bus
);
   logic [KEY_WIDTH-1:0]   key_q [NUM_ENTRIES];
   logic [VALUE_WIDTH-1:0] val_q [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] used_q, used_d, match, first, resp_idx_q;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic [VALUE_WIDTH-1:0] hit_value, resp_value_q;
   logic                   wr_ok, del_ok, multi, full_q;
   logic                   resp_valid_q, resp_hit_q, cmd_err_q, multi_hit_q;

   for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_match
      assign match[i] = used_q[i] && key_q[i] == bus.lookup_key;
   end

   always_comb begin
      wr_ok  = bus.wr_en && $onehot(bus.wr_idx);
      del_ok = bus.del_en && $onehot(bus.del_idx);
      // OR-ing the write in after the delete mask lets a same-slot write win
      used_d = (used_q & ~(del_ok ? bus.del_idx : '0)) | (wr_ok ? bus.wr_idx : '0);
      count_d = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) count_d = count_d + CNT_WIDTH'(used_d[i]);
      first = match & (~match + NUM_ENTRIES'(1));
      multi = |(match & (match - NUM_ENTRIES'(1)));
      hit_value = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) hit_value = hit_value | (first[i] ? val_q[i] : '0);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (wr_ok && bus.wr_idx[i]) begin
            key_q[i] <= bus.wr_key;
            val_q[i] <= bus.wr_value;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         used_q       <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_idx_q   <= '0;
         resp_value_q <= '0;
         cmd_err_q    <= 1'b0;
         multi_hit_q  <= 1'b0;
      end else begin
         used_q       <= used_d;
         count_q      <= count_d;
         full_q       <= count_d == CNT_WIDTH'(NUM_ENTRIES);
         resp_valid_q <= bus.lookup_valid;
         cmd_err_q    <= (bus.wr_en && !wr_ok) || (bus.del_en && !del_ok);
         multi_hit_q  <= multi_hit_q || (bus.lookup_valid && multi);
         if (bus.lookup_valid) begin
            resp_hit_q   <= |match;
            resp_idx_q   <= first;
            resp_value_q <= hit_value;
         end
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_hit   = resp_hit_q;
   assign bus.resp_idx   = resp_idx_q;
   assign bus.resp_value = resp_value_q;
   assign bus.used       = used_q;
   assign bus.count      = count_q;
   assign bus.full       = full_q;
   assign bus.cmd_err    = cmd_err_q;
   assign bus.multi_hit  = multi_hit_q;
endmodule

// File: tb/tb_key_store_cam.sv
// tb_key_store_cam: directed plus random stimulus against a slot-array model;
// expected lookup responses go through a scoreboard queue checked by a monitor.
module tb_key_store_cam;
   typedef struct packed {
      logic        hit;
      logic [15:0] idx;
      logic [63:0] val;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [63:0] m_key [16];
   logic [63:0] m_val [16];
   logic [15:0] m_used = '0;
   logic        exp_cmd_err = 1'b0;
   logic        exp_multi = 1'b0;
   rsp_t        sb [$];
   rsp_t        last = '0;

   key_store_cam_if #(.NUM_ENTRIES(16), .KEY_WIDTH(64), .VALUE_WIDTH(64)) bus ();

   key_store_cam #(.NUM_ENTRIES(16), .KEY_WIDTH(64), .VALUE_WIDTH(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s got %h expected %h", n, a, x);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         last = '0;
         chk("rst_resp_valid", 64'(bus.resp_valid), 0);
         chk("rst_resp_idx", 64'(bus.resp_idx), 0);
         chk("rst_used", 64'(bus.used), 0);
         chk("rst_count", 64'(bus.count), 0);
         chk("rst_flags", 64'({bus.full, bus.cmd_err, bus.multi_hit, bus.resp_hit}), 0);
      end else begin
         if (bus.resp_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_resp", 64'(bus.resp_valid), 0);
            end else begin
               last = sb.pop_front();
               chk("resp_hit", 64'(bus.resp_hit), 64'(last.hit));
               chk("resp_idx", 64'(bus.resp_idx), 64'(last.idx));
               chk("resp_value", bus.resp_value, last.val);
            end
         end else begin
            chk("missing_resp", 64'(sb.size()), 0);
            chk("hold_resp", {bus.resp_hit, bus.resp_idx, bus.resp_value[46:0]},
                {last.hit, last.idx, last.val[46:0]});
         end
         chk("used", 64'(bus.used), 64'(m_used));
         chk("count", 64'(bus.count), 64'($countones(m_used)));
         chk("full", 64'(bus.full), 64'(m_used == 16'hFFFF));
         chk("cmd_err", 64'(bus.cmd_err), 64'(exp_cmd_err));
         chk("multi_hit", 64'(bus.multi_hit), 64'(exp_multi));
      end
   end

   task automatic step(input logic lv, input logic [63:0] lk, input logic we, input logic [15:0] wi,
                       input logic [63:0] wk, input logic [63:0] wv, input logic de, input logic [15:0] di);
      rsp_t e;
      int   nm;
      logic wok, dok;
      bus.lookup_valid = lv;
      bus.lookup_key   = lk;
      bus.wr_en        = we;
      bus.wr_idx       = wi;
      bus.wr_key       = wk;
      bus.wr_value     = wv;
      bus.del_en       = de;
      bus.del_idx      = di;
      e  = '0;
      nm = 0;
      for (int i = 0; i < 16; i++) begin
         if (m_used[i] && m_key[i] == lk) begin
            if (nm == 0) begin
               e.hit    = 1'b1;
               e.idx[i] = 1'b1;
               e.val    = m_val[i];
            end
            nm++;
         end
      end
      wok = we && $countones(wi) == 1;
      dok = de && $countones(di) == 1;
      @(posedge clk);
      #1;
      if (dok) m_used = m_used & ~di;
      for (int i = 0; i < 16; i++) begin
         if (wok && wi[i]) begin
            m_key[i]  = wk;
            m_val[i]  = wv;
            m_used[i] = 1'b1;
         end
      end
      exp_cmd_err = (we && !wok) || (de && !dok);
      if (lv) begin
         sb.push_back(e);
         if (nm > 1) exp_multi = 1'b1;
      end
      bus.lookup_valid = 1'b0;
      bus.wr_en        = 1'b0;
      bus.del_en       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic lookup(input logic [63:0] k);
      step(1, k, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset(input logic mid);
      if (mid) begin
         bus.lookup_valid = 1'b1;
         bus.lookup_key   = 64'h11;
      end
      #2;
      rst_n = 1'b0;
      bus.lookup_valid = 1'b0;
      m_used      = '0;
      exp_cmd_err = 1'b0;
      exp_multi   = 1'b0;
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [15:0] rand_idx();
      int r;
      r = int'($urandom_range(0, 9));
      return r == 0 ? 16'h0 : r == 1 ? 16'($urandom) : 16'(1) << $urandom_range(0, 15);
   endfunction

   initial begin
      bus.lookup_valid = 1'b0;
      bus.lookup_key   = '0;
      bus.wr_en        = 1'b0;
      bus.wr_idx       = '0;
      bus.wr_key       = '0;
      bus.wr_value     = '0;
      bus.del_en       = 1'b0;
      bus.del_idx      = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      lookup(64'hA5);
      step(1, 64'h11, 1, 16'h0008, 64'h11, 64'hBEEF, 0, 0);
      lookup(64'h11);
      lookup(64'h11);
      for (int i = 0; i < 16; i++) step(0, 0, 1, 16'(1) << i, 64'(i), 64'(i) * 64'h101 + 64'h7, 0, 0);
      lookup(64'h3);
      step(0, 0, 1, 16'h8000, 64'h99, 64'hCAFE, 1, 16'h8000);
      lookup(64'h99);
      lookup(64'hF);
      step(0, 0, 1, 16'h0003, 64'h55, 64'h1, 0, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 1, 16'h0000);
      step(0, 0, 0, 0, 0, 0, 1, 16'h0004);
      step(0, 0, 1, 16'h0002, 64'h22, 64'h2222, 0, 0);
      step(0, 0, 1, 16'h0020, 64'h22, 64'h5555, 0, 0);
      lookup(64'h22);
      lookup(64'h0);
      lookup(64'h77);
      step(0, 0, 1, 16'h0001, 64'hAA, 64'hA, 1, 16'h0004);
      idle(1);
      do_reset(1'b1);
      idle(2);
      for (int n = 0; n < 800; n++) begin
         step(1'($urandom_range(0, 2) != 0), 64'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), rand_idx(), 64'($urandom_range(0, 7)), {$urandom, $urandom},
              1'($urandom_range(0, 2) == 0), rand_idx());
         if (n == 400) do_reset(1'b0);
      end
      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
